// File: rtl/stage_d.sv
// Output buffering stage behind stage_C: a small circular FIFO with a DIR/ack_from
// capture handshake upstream and a DOR/ack_to handshake downstream.
module stage_d #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     DIR,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ack_from,
  output logic                     DOR,
  output logic [WIDTH-1:0]         data_out,
  input  logic                     ack_to,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [AW:0] FULL_LVL = PW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic             ack_q, ack_d;
  logic [AW:0]      level_w;
  logic             full_w;
  logic             empty_w;
  logic             push_w;
  logic             pop_w;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_w = wp_q - rp_q;
  assign full_w  = (level_w == FULL_LVL);
  assign empty_w = (level_w == '0);

  // ack_from high blocks re-capture of the word upstream still holds.
  assign push_w = DIR && !full_w && !ack_q;
  assign pop_w  = !empty_w && ack_to;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ack_d = 1'b0;
    if (push_w) begin
      wp_d  = wp_q + 1'b1;
      ack_d = 1'b1;
    end
    if (pop_w) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ack_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ack_q <= ack_d;
    end
  end

  // Storage is not reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wp_q[AW-1:0]] <= data_in;
    end
  end

  assign ack_from = ack_q;
  assign DOR      = !empty_w;
  assign data_out = mem_q[rp_q[AW-1:0]];
  assign level    = level_w;

endmodule

// File: tb/tb_stage_d.sv
// Bench for stage_d: directed steps plus randomized downstream stalls, checked
// against a queue-based model of the FIFO and of a well-behaved upstream source.
module tb_stage_d;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             DIR;
  logic [WIDTH-1:0] data_in;
  logic             ack_from;
  logic             DOR;
  logic [WIDTH-1:0] data_out;
  logic             ack_to;
  logic [2:0]       level;

  int vectors;
  int miscompares;

  logic [7:0] q[$];
  logic [7:0] src[$];
  logic [7:0] popped[$];
  logic       m_ack;

  stage_d #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .DIR      (DIR),
    .data_in  (data_in),
    .ack_from (ack_from),
    .DOR      (DOR),
    .data_out (data_out),
    .ack_to   (ack_to),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: upstream presents its head word (held until acked), model predicts the edge.
  task automatic step(input logic ak);
    logic       push;
    logic       pop;
    logic       ackprev;
    logic [7:0] din;
    DIR     = (src.size() > 0);
    data_in = (src.size() > 0) ? src[0] : 8'h00;
    ack_to  = ak;
    din     = data_in;
    ackprev = m_ack;
    push    = DIR && (q.size() < DEPTH) && !m_ack;
    pop     = (q.size() > 0) && ak;
    if (pop) popped.push_back(data_out);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(din);
    if (ackprev) void'(src.pop_front());
    m_ack = push;
    chk("dor", {31'd0, DOR}, {31'd0, (q.size() > 0)});
    chk("level", {29'd0, level}, q.size());
    chk("ack_from", {31'd0, ack_from}, {31'd0, m_ack});
    if (q.size() > 0) chk("data_out", {24'd0, data_out}, {24'd0, q[0]});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ack       = 1'b0;
    reset       = 1'b0;
    DIR         = 1'b0;
    data_in     = '0;
    ack_to      = 1'b0;

    #12;
    chk("rst_dor", {31'd0, DOR}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ack", {31'd0, ack_from}, 32'd0);
    reset = 1'b1;

    // Single word
    src.push_back(8'hA5);
    step(1'b0);
    chk("single_ack_hi", {31'd0, ack_from}, 32'd1);
    chk("single_level", {29'd0, level}, 32'd1);
    chk("single_data", {24'd0, data_out}, 32'hA5);
    step(1'b0);
    chk("single_ack_lo", {31'd0, ack_from}, 32'd0);
    step(1'b1);
    chk("single_empty_level", {29'd0, level}, 32'd0);
    chk("single_empty_dor", {31'd0, DOR}, 32'd0);

    // Fill and backpressure
    for (int i = 1; i <= 5; i++) src.push_back(8'(i));
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("fill_level", {29'd0, level}, 32'd4);
    chk("fill_held_word", {24'd0, data_in}, 32'h05);
    chk("fill_no_ack", {31'd0, ack_from}, 32'd0);
    step(1'b1);
    chk("fill_after_pop", {29'd0, level}, 32'd3);
    step(1'b0);
    chk("fill_capture5", {29'd0, level}, 32'd4);
    chk("fill_ack5", {31'd0, ack_from}, 32'd1);
    chk("fill_head", {24'd0, data_out}, 32'h02);
    for (int i = 0; i < 20 && (q.size() > 0 || src.size() > 0 || m_ack); i++) step(1'b1);
    chk("fill_drained", q.size() + src.size(), 32'd0);

    // Wrap-around ordering with random downstream stalls
    popped.delete();
    for (int i = 0; i < 32; i++) src.push_back(8'(i));
    for (int i = 0; i < 1000 && (q.size() > 0 || src.size() > 0 || m_ack); i++)
      step(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1);
    chk("wrap_done", q.size() + src.size(), 32'd0);
    chk("wrap_count", popped.size(), 32'd32);
    for (int i = 0; i < popped.size(); i++) chk("wrap_order", {24'd0, popped[i]}, i);

    // Simultaneous push and pop at level 2
    src.push_back(8'h10);
    src.push_back(8'h11);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("sim_level2", {29'd0, level}, 32'd2);
    src.push_back(8'h12);
    step(1'b1);
    chk("sim_level_kept", {29'd0, level}, 32'd2);
    chk("sim_head", {24'd0, data_out}, 32'h11);
    step(1'b0);

    // Held ack_to at level 3
    src.push_back(8'h13);
    step(1'b0);
    step(1'b0);
    chk("held_level3", {29'd0, level}, 32'd3);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("held_level0", {29'd0, level}, 32'd0);
    chk("held_dor0", {31'd0, DOR}, 32'd0);
    step(1'b0);

    // Asynchronous reset mid-transfer with an ack_from pulse in flight
    src.push_back(8'h21);
    src.push_back(8'h22);
    src.push_back(8'h23);
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("pre_rst_level3", {29'd0, level}, 32'd3);
    chk("pre_rst_ack", {31'd0, ack_from}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_dor", {31'd0, DOR}, 32'd0);
    chk("async_rst_level", {29'd0, level}, 32'd0);
    chk("async_rst_ack", {31'd0, ack_from}, 32'd0);
    q.delete();
    src.delete();
    m_ack = 1'b0;
    DIR   = 1'b0;
    #1 reset = 1'b1;
    src.push_back(8'h5A);
    step(1'b0);
    chk("post_rst_dor", {31'd0, DOR}, 32'd1);
    chk("post_rst_data", {24'd0, data_out}, 32'h5A);
    step(1'b0);
    step(1'b1);
    chk("post_rst_empty", {29'd0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_d.md
# stage_d

Output buffering stage placed directly downstream of `stage_C`, the last stage of the `pipeline` chain. It consumes `stage_C`'s `DOR`/`data_out` stream, using the same DIR/ack handshake as every other stage. It holds words in a small circular FIFO so the pipeline keeps draining while the final consumer stalls, and presents them again on the same DOR/ack handshake on its output side.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 4, FIFO entries; power of two, minimum 2
- `clk`  in  1  single system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low
- `DIR`  in  1  Data In Ready from upstream (`stage_C`'s `DOR`); `data_in` valid while high
- `data_in`  in  WIDTH  input word, stable while `DIR` high
- `ack_from`  out  1  one-cycle capture acknowledge to upstream (drives `stage_C`'s `ack_to`)
- `DOR`  out  1  Data Out Ready to the downstream consumer; `data_out` valid while high
- `data_out`  out  WIDTH  FIFO head word
- `ack_to`  in  1  one-cycle consume pulse from downstream
- `level`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×WIDTH register array; write pointer `wp` and read pointer `rp`, each log2(DEPTH)+1 bits, incrementing modulo 2·DEPTH.
- `level` = `wp` − `rp` (modulo 2·DEPTH). Empty when `level`=0; full when `level`=DEPTH.
- Index into the array with the low log2(DEPTH) bits of each pointer. Wrap-around from entry DEPTH−1 to entry 0 is seamless.
- Push condition, evaluated at a rising edge: `DIR`=1 AND not full AND `ack_from`=0.
  - On push, write `data_in` at `wp`, increment `wp`, and set `ack_from`←1 for exactly one cycle.
  - `ack_from`=1 blocks a second capture of the same word.
- Pop condition, evaluated at a rising edge: `DOR`=1 AND `ack_to`=1. On pop, increment `rp`.
- `DOR` = not empty (combinational from the pointers). `data_out` = array[`rp`] (combinational read).
- Push and pop in the same edge are both performed, so `level` is unchanged.
- Push when full: suppressed. `ack_from` stays 0 and upstream holds its word.
- Pop when empty: impossible because `DOR`=0. An `ack_to` received while `DOR`=0 is ignored.
- Reset (`reset`=0, asynchronous): `wp`←0, `rp`←0, `ack_from`←0.
  - Outputs during and after reset: `DOR`=0, `level`=0.
  - Array contents are not reset. `data_out` is don't-care while `DOR`=0.
  - Reset mid-transfer discards all buffered words. An in-flight `ack_from` pulse is cancelled.

## Timing
- Upstream rule: on the edge at which upstream samples `ack_from`=1, it drops `DIR` or presents the next word.
- Input throughput: at most one word per 2 cycles (capture edge, then ack edge).
- Push-to-output latency: a word pushed into an empty FIFO at edge k gives `DOR`=1 with that word on `data_out` after edge k, i.e. 1 cycle.
- Downstream rule: `ack_to` is a single-cycle pulse per word consumed. A level-held `ack_to` pops one word per cycle.
- Full-to-accept latency: a pop at edge k makes the FIFO non-full after edge k. A pending `DIR` is captured at edge k+1.
- `level` updates one edge after each push or pop. No combinational path from `DIR` or `data_in` to any output.

## Test plan
- Reset behaviour:
  - Stimulus: assert `reset`=0 asynchronously between clock edges while `level`=3.
  - Response: `DOR`=0 and `level`=0 immediately, and `ack_from`=0.
  - Response after release: the next `DIR` word 0x5A gives `DOR`=1 with `data_out`=0x5A one cycle after its capture.
- Single word:
  - Stimulus: `DIR`=1 with 0xA5, upstream obeying the upstream rule.
  - Response: `ack_from` high for exactly 1 cycle, `level`=1, then `data_out`=0xA5.
  - Response: `ack_to` pulse gives `level`=0 and `DOR`=0.
- Fill and backpressure:
  - Stimulus: push 0x01..0x05 with `ack_to`=0.
  - Response: 0x01..0x04 accepted and `level`=4. 0x05 receives no `ack_from` while full.
  - Stimulus: one `ack_to` pulse.
  - Response: 0x05 captured on the following edge.
- Wrap-around ordering:
  - Stimulus: stream 0x00..0x1F with random `ack_to` gaps.
  - Response: output sequence exactly 0x00..0x1F, no loss or duplication, pointers wrapping several times.
- Simultaneous push and pop:
  - Stimulus: `level`=2; push and pop coincide on the same edge.
  - Response: `level` stays 2 and the head advances to the next word.
- Held `ack_to`:
  - Stimulus: `level`=3, hold `ack_to`=1 for 4 cycles.
  - Response: 3 pops over 3 cycles, then `DOR`=0. The 4th cycle is ignored and `level` stays 0.
